fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the Fetch stage against a variable-latency instruction memory.
//  Drives the PC register enable (enablePCFlipFlop), issues req/ack fetches,
//  and buffers the returned word while Decode stalls.
//  Kills or discards stale fetches on redirect (BranchTakenE | PCSrcW).
//  Sits between Fetch, the hazard logic and the IMEM port.
// PARAMETERS
//  WIDTH    32  PC / IMEM address width
//  INSTR_W  32  instruction word width
//  MAX_WAIT 15  cycles without imem_ack before TimeoutErr sets
// PORTS
//  clk              in   1        clock, all state updates on rising edge
//  reset            in   1        synchronous, active-high
//  PCF              in   WIDTH    current PC, from the Fetch PC register
//  PCPlus8F         in   WIDTH    PCF+8, from the Fetch adder
//  BranchTakenE     in   1        Execute branch redirect
//  PCSrcW           in   1        Writeback PC-write redirect
//  StallD           in   1        Decode cannot accept an instruction
//  imem_ack         in   1        outstanding request completes; rdata valid
//  imem_rdata       in   INSTR_W  instruction data, valid with imem_ack
//  imem_req         out  1        request outstanding (level, registered)
//  imem_addr        out  WIDTH    request address (registered, stable while req=1)
//  enablePCFlipFlop out  1        PC register load enable (combinational)
//  InstrValidF      out  1        InstrF valid for Decode (combinational)
//  InstrF           out  INSTR_W  instruction to Decode
//  FlushD           out  1        kill the Decode register (combinational)
//  TimeoutErr       out  1        sticky error flag
// BEHAVIOUR
//  Reset values
//  - state=IDLE; imem_req, imem_addr, wait_cnt, hold buffer, TimeoutErr = 0.
//  - Combinational outputs are 0 while reset is high.
//  Redirect
//  - redir = BranchTakenE | PCSrcW. Whenever redir=1, in any state:
//    FlushD=1, enablePCFlipFlop=1, InstrValidF=0.
//  - Otherwise FlushD=0.
//  Default outputs
//  - enablePCFlipFlop=0 and InstrValidF=0 unless a rule below says otherwise.
//  IDLE (no request outstanding)
//  - !redir: imem_addr<=PCF, imem_req<=1, go to WAIT.
//  - redir: stay in IDLE; PC loads the target and the request issues next cycle.
//  WAIT (live request)
//  - ack & !redir & !StallD: InstrValidF=1, InstrF=imem_rdata,
//    enablePCFlipFlop=1, imem_addr<=PCPlus8F, stay in WAIT.
//    Back-to-back fetches; 1 instr/cycle when ack is same-cycle.
//  - ack & !redir & StallD: hold buffer<=imem_rdata, imem_req<=0, go to HOLD.
//    InstrValidF=1 this cycle; Decode does not capture it.
//  - redir & ack: drop the word, imem_req<=0, go to IDLE.
//  - redir & !ack: go to DISCARD; imem_req stays 1 at the old address.
//  DISCARD (stale request)
//  - ack: drop the data, imem_req<=0, go to IDLE.
//  - Further redirects stay in DISCARD.
//  HOLD (word buffered, Decode stalled)
//  - InstrValidF=1 and InstrF=buffer while !redir.
//  - !StallD & !redir: enablePCFlipFlop=1, imem_addr<=PCPlus8F, imem_req<=1,
//    go to WAIT.
//  - redir: drop the buffer, go to IDLE.
//  Other rules
//  - imem_req=1 exactly in WAIT/DISCARD. imem_addr changes only on issue.
//  - wait_cnt clears on every issue and increments on each req cycle without ack.
//  - wait_cnt saturates at MAX_WAIT; when it reaches MAX_WAIT, TimeoutErr<=1
//    (sticky until reset). The request stays outstanding.
//  - imem_ack while imem_req=0 is ignored.
//  - Reset mid-operation returns to IDLE at once; IMEM shares the same reset.
// TESTING
//  T1 reset 2 cycles, PCF=0, ack same cycle every req -> req at 0,8,16;
//     InstrValidF=1 each cycle from cycle 2; enablePCFlipFlop=1 each ack.
//  T2 ack latency 3 -> enablePCFlipFlop and InstrValidF pulse once per 3 cycles;
//     imem_addr is stable across the wait.
//  T3 StallD=1 for 4 cycles when ack=1 with rdata=0xE3A01005 -> HOLD;
//     InstrF=0xE3A01005 and valid throughout; req=0; PC frozen;
//     StallD=0 -> next req at PCPlus8F.
//  T4 BranchTakenE in cycle 1 of a 3-cycle wait -> FlushD=1, PC enable=1;
//     late ack dropped with InstrValidF=0; new req at the branch target.
//  T5 PCSrcW while in HOLD -> buffer dropped, FlushD=1, IDLE, then req at new PC.
//  T6 no ack for 15 cycles -> TimeoutErr=1 and sticky; late ack still accepted;
//     reset clears it.

Source files
------------

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: Fetch/hazard/IMEM signal bundle for fetch_controller.
// Rev 1.0
`default_nettype none

interface fetch_controller_if #(
  parameter int WIDTH   = 32,
  parameter int INSTR_W = 32
);
  logic [WIDTH-1:0]   PCF;
  logic [WIDTH-1:0]   PCPlus8F;
  logic               BranchTakenE;
  logic               PCSrcW;
  logic               StallD;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_req;
  logic [WIDTH-1:0]   imem_addr;
  logic               enablePCFlipFlop;
  logic               InstrValidF;
  logic [INSTR_W-1:0] InstrF;
  logic               FlushD;
  logic               TimeoutErr;

  modport master (
    input  PCF, PCPlus8F, BranchTakenE, PCSrcW, StallD, imem_ack, imem_rdata,
    output imem_req, imem_addr, enablePCFlipFlop, InstrValidF, InstrF, FlushD,
           TimeoutErr
  );

  modport slave (
    output PCF, PCPlus8F, BranchTakenE, PCSrcW, StallD, imem_ack, imem_rdata,
    input  imem_req, imem_addr, enablePCFlipFlop, InstrValidF, InstrF, FlushD,
           TimeoutErr
  );
endinterface

`default_nettype wire

// File: rtl/fetch_controller.sv
// fetch_controller: sequences Fetch against a variable-latency IMEM (req/ack).
// Rev 1.0
`default_nettype none

module fetch_controller #(
  parameter int WIDTH    = 32,
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 15
) (
  input  wire                 clk,
  input  wire                 reset,
  fetch_controller_if.master  bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic               err_q, err_d;
  logic               redir;
  logic [CW-1:0]      cnt_inc;

  assign redir   = bus.BranchTakenE | bus.PCSrcW;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (!redir) begin
          addr_d  = bus.PCF;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_ack) begin
          if (redir) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else if (bus.StallD) begin
            hold_d  = bus.imem_rdata;
            req_d   = 1'b0;
            state_d = S_HOLD;
          end else begin
            addr_d = bus.PCPlus8F;
            cnt_d  = '0;
          end
        end else begin
          // A redirect cannot cancel an issued request; wait out its ack.
          if (redir) state_d = S_DISCARD;
          cnt_d = cnt_inc;
        end
      end
      S_DISCARD: begin
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_IDLE;
        end else if (!bus.StallD) begin
          addr_d  = bus.PCPlus8F;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cnt_d == CNT_MAX) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.FlushD           = 1'b0;
    bus.enablePCFlipFlop = 1'b0;
    bus.InstrValidF      = 1'b0;
    bus.InstrF           = '0;
    if (!reset) begin
      bus.FlushD           = redir;
      bus.InstrF           = (state_q == S_HOLD) ? hold_q : bus.imem_rdata;
      bus.InstrValidF      = !redir && ((state_q == S_WAIT && bus.imem_ack) ||
                                        state_q == S_HOLD);
      bus.enablePCFlipFlop = redir ||
                             (state_q == S_WAIT && bus.imem_ack && !bus.StallD) ||
                             (state_q == S_HOLD && !bus.StallD);
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.TimeoutErr = err_q;
endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch_controller with a PC register model.
// Rev 1.0
`default_nettype none

module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_q;
  logic [31:0] target;
  int          total = 0;
  int          bad   = 0;

  fetch_controller_if #(.WIDTH(32), .INSTR_W(32)) bus ();

  fetch_controller #(.WIDTH(32), .INSTR_W(32), .MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Fetch PC register: loads the redirect target or PC+8 when enabled.
  always @(posedge clk) begin
    if (reset) pc_q <= 32'd0;
    else if (bus.enablePCFlipFlop)
      pc_q <= (bus.BranchTakenE | bus.PCSrcW) ? target : pc_q + 32'd8;
  end
  assign bus.PCF      = pc_q;
  assign bus.PCPlus8F = pc_q + 32'd8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven at +1 and outputs checked at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rd, input logic stall,
                       input logic bt, input logic pcs);
    bus.imem_ack     = ack;
    bus.imem_rdata   = rd;
    bus.StallD       = stall;
    bus.BranchTakenE = bt;
    bus.PCSrcW       = pcs;
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    target = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rst_req",    32'(bus.imem_req), 32'd0);
    chk("rst_addr",   bus.imem_addr, 32'd0);
    chk("rst_flush",  32'(bus.FlushD), 32'd0);
    chk("rst_pcen",   32'(bus.enablePCFlipFlop), 32'd0);
    chk("rst_valid",  32'(bus.InstrValidF), 32'd0);
    chk("rst_err",    32'(bus.TimeoutErr), 32'd0);
    reset = 1'b0;

    // T1: same-cycle ack, back-to-back fetches
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_idle_valid", 32'(bus.InstrValidF), 32'd0);
    chk("t1_idle_pcen",  32'(bus.enablePCFlipFlop), 32'd0);
    tick();
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    chk("t1_req0",   32'(bus.imem_req), 32'd1);
    chk("t1_addr0",  bus.imem_addr, 32'd0);
    chk("t1_valid0", 32'(bus.InstrValidF), 32'd1);
    chk("t1_instr0", bus.InstrF, 32'h11);
    chk("t1_pcen0",  32'(bus.enablePCFlipFlop), 32'd1);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    chk("t1_addr8",  bus.imem_addr, 32'd8);
    chk("t1_valid1", 32'(bus.InstrValidF), 32'd1);
    chk("t1_instr1", bus.InstrF, 32'h22);
    tick();

    // T2: ack latency of 3 cycles at address 16
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_addr16", bus.imem_addr, 32'd16);
    chk("t2_valid_w1", 32'(bus.InstrValidF), 32'd0);
    chk("t2_pcen_w1",  32'(bus.enablePCFlipFlop), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_addr_stable", bus.imem_addr, 32'd16);
    chk("t2_valid_w2", 32'(bus.InstrValidF), 32'd0);
    tick();
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    chk("t2_valid_ack", 32'(bus.InstrValidF), 32'd1);
    chk("t2_pcen_ack",  32'(bus.enablePCFlipFlop), 32'd1);
    chk("t2_instr",     bus.InstrF, 32'h33);
    tick();

    // T3: Decode stall with word returned -> HOLD
    drive(1'b1, 32'hE3A01005, 1'b1, 1'b0, 1'b0);
    chk("t3_addr24",   bus.imem_addr, 32'd24);
    chk("t3_valid_in", 32'(bus.InstrValidF), 32'd1);
    chk("t3_pcen_in",  32'(bus.enablePCFlipFlop), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 32'hBAD0BAD0, 1'b1, 1'b0, 1'b0);
      chk("t3_hold_req",   32'(bus.imem_req), 32'd0);
      chk("t3_hold_valid", 32'(bus.InstrValidF), 32'd1);
      chk("t3_hold_instr", bus.InstrF, 32'hE3A01005);
      chk("t3_hold_pcen",  32'(bus.enablePCFlipFlop), 32'd0);
      chk("t3_hold_pc",    bus.PCF, 32'd24);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_pcen",  32'(bus.enablePCFlipFlop), 32'd1);
    chk("t3_rel_instr", bus.InstrF, 32'hE3A01005);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_req",  32'(bus.imem_req), 32'd1);
    chk("t3_rel_addr", bus.imem_addr, 32'd32);

    // T4: branch during a 3-cycle wait -> DISCARD, late ack dropped
    target = 32'h100;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_flush", 32'(bus.FlushD), 32'd1);
    chk("t4_pcen",  32'(bus.enablePCFlipFlop), 32'd1);
    chk("t4_valid", 32'(bus.InstrValidF), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t4_disc_req",   32'(bus.imem_req), 32'd1);
    chk("t4_disc_addr",  bus.imem_addr, 32'd32);
    chk("t4_disc_flush", 32'(bus.FlushD), 32'd0);
    chk("t4_pc_target",  bus.PCF, 32'h100);
    tick();
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("t4_late_valid", 32'(bus.InstrValidF), 32'd0);
    chk("t4_late_pcen",  32'(bus.enablePCFlipFlop), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t4_idle_req", 32'(bus.imem_req), 32'd0);
    tick();
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    chk("t4_new_req",  32'(bus.imem_req), 32'd1);
    chk("t4_new_addr", bus.imem_addr, 32'h100);
    tick();

    // T5: PCSrcW while in HOLD
    target = 32'h200;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t5_hold_req", 32'(bus.imem_req), 32'd0);
    chk("t5_flush",    32'(bus.FlushD), 32'd1);
    chk("t5_valid",    32'(bus.InstrValidF), 32'd0);
    chk("t5_pcen",     32'(bus.enablePCFlipFlop), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t5_idle_req",   32'(bus.imem_req), 32'd0);
    chk("t5_idle_valid", 32'(bus.InstrValidF), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t5_new_req",  32'(bus.imem_req), 32'd1);
    chk("t5_new_addr", bus.imem_addr, 32'h200);

    // T6: timeout after 15 ack-less request cycles
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) chk("t6_err_before", 32'(bus.TimeoutErr), 32'd0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("t6_err_set", 32'(bus.TimeoutErr), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("t6_err_sticky", 32'(bus.TimeoutErr), 32'd1);
    chk("t6_req_held",   32'(bus.imem_req), 32'd1);
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    chk("t6_late_valid", 32'(bus.InstrValidF), 32'd1);
    chk("t6_late_instr", bus.InstrF, 32'h77);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_err_after_ack", 32'(bus.TimeoutErr), 32'd1);
    chk("t6_next_addr",     bus.imem_addr, 32'h208);
    reset = 1'b1;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_err", 32'(bus.TimeoutErr), 32'd0);
    chk("t6_rst_req", 32'(bus.imem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
